irq_or_collector: RTL and testbench

Upstream stage for the team's OR-reduction gates. Takes N asynchronous event lines and synchronises each one. Latches each line into a sticky pending bit, per-source edge or level. Presents a registered, masked OR of the pending bits as a single interrupt, plus the lowest-index active source. Pending and overrun bits are cleared with a one-cycle valid/ack handshake.

---
 rtl/irq_or_collector.sv | 80 ++++++++
 tb/tb_irq_or_collector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_or_collector.sv
// Interrupt request collector: synchronises N async request lines, latches them into
// sticky pending/overrun bits and presents a registered masked OR plus lowest active id.
module irq_or_collector #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int IDW         = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_in,
    input  logic [N-1:0]   edge_mode,
    input  logic [N-1:0]   mask,
    input  logic           clr_valid,
    input  logic [N-1:0]   clr_mask,
    output logic           clr_ack,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   overrun,
    output logic           irq_out,
    output logic [IDW-1:0] src_id
);

    // Handshake: clr_valid is accepted on every cycle it is high (no back-pressure);
    // clr_ack pulses exactly one cycle later for each accepted clr_valid.

    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  s;
    logic [N-1:0]                  p;
    logic [N-1:0]                  ev;
    logic [N-1:0]                  clr;
    logic [N-1:0]                  act;
    logic [N-1:0]                  pending_next;
    logic [N-1:0]                  overrun_next;
    logic [IDW-1:0]                sel_id;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            p      <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
            p      <= s;
        end
    end

    // Edge history resets to 0, so a line held high through reset yields one edge event.
    always_comb begin
        ev  = (edge_mode & s & ~p) | (~edge_mode & s);
        clr = clr_valid ? clr_mask : '0;
        pending_next = ev | (pending & ~clr);
        overrun_next = (ev & pending & ~clr) | (overrun & ~clr);
    end

    assign act = pending & mask;

    always_comb begin
        sel_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (act[i]) sel_id = IDW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            overrun <= '0;
            irq_out <= 1'b0;
            src_id  <= '0;
            clr_ack <= 1'b0;
        end else begin
            pending <= pending_next;
            overrun <= overrun_next;
            irq_out <= |act;
            src_id  <= sel_id;
            clr_ack <= clr_valid;
        end
    end

endmodule

// File: tb/tb_irq_or_collector.sv
// Directed bench for irq_or_collector: hand-computed vectors checked after each rising edge.
module tb_irq_or_collector;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_in;
    logic [N-1:0]   edge_mode;
    logic [N-1:0]   mask;
    logic           clr_valid;
    logic [N-1:0]   clr_mask;
    logic           clr_ack;
    logic [N-1:0]   pending;
    logic [N-1:0]   overrun;
    logic           irq_out;
    logic [IDW-1:0] src_id;

    int n_checks = 0;
    int n_fail   = 0;

    irq_or_collector #(.N(N), .SYNC_STAGES(2), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .edge_mode (edge_mode),
        .mask      (mask),
        .clr_valid (clr_valid),
        .clr_mask  (clr_mask),
        .clr_ack   (clr_ack),
        .pending   (pending),
        .overrun   (overrun),
        .irq_out   (irq_out),
        .src_id    (src_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle clear strobe; on return the clear edge has just passed.
    task automatic do_clear(input logic [N-1:0] m);
        clr_valid = 1'b1;
        clr_mask  = m;
        step();
        clr_valid = 1'b0;
        clr_mask  = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_in    = '0;
        edge_mode = '0;
        mask      = '0;
        clr_valid = 1'b0;
        clr_mask  = '0;
        #2;
        check_eq("reset_pending", 32'(pending), 32'h0);
        check_eq("reset_irq", 32'(irq_out), 32'h0);
        step(2);
        rst_n     = 1'b1;
        edge_mode = 4'b1111;
        mask      = 4'b1111;
        step(2);

        // Single edge event on source 2
        req_in = 4'b0100;
        step(2);
        check_eq("t1_pending_early", 32'(pending), 32'h0);
        step();
        check_eq("t1_pending", 32'(pending), 32'h4);
        check_eq("t1_irq_early", 32'(irq_out), 32'h0);
        req_in = 4'b0000;
        step();
        check_eq("t1_irq", 32'(irq_out), 32'h1);
        check_eq("t1_src", 32'(src_id), 32'h2);
        check_eq("t1_overrun", 32'(overrun), 32'h0);
        do_clear(4'b1111);
        check_eq("t1_ack", 32'(clr_ack), 32'h1);
        check_eq("t1_cleared", 32'(pending), 32'h0);
        step(3);
        check_eq("t1_ack_gone", 32'(clr_ack), 32'h0);

        // Priority with mask, then partial clear
        mask   = 4'b1000;
        req_in = 4'b1010;
        step(4);
        req_in = 4'b0000;
        check_eq("t2_pending", 32'(pending), 32'ha);
        check_eq("t2_irq", 32'(irq_out), 32'h1);
        check_eq("t2_src", 32'(src_id), 32'h3);
        do_clear(4'b1000);
        check_eq("t2_ack", 32'(clr_ack), 32'h1);
        check_eq("t2_pending_clr", 32'(pending), 32'h2);
        step();
        check_eq("t2_irq_low", 32'(irq_out), 32'h0);
        check_eq("t2_src_zero", 32'(src_id), 32'h0);
        mask = 4'b1111;
        step();
        check_eq("t2_unmask_irq", 32'(irq_out), 32'h1);
        check_eq("t2_unmask_src", 32'(src_id), 32'h1);
        do_clear(4'b1111);
        step(3);

        // Second edge on source 0 before clear -> overrun
        req_in = 4'b0001;
        step(3);
        check_eq("t3_pending", 32'(pending), 32'h1);
        check_eq("t3_no_overrun", 32'(overrun), 32'h0);
        req_in = 4'b0000;
        step(3);
        req_in = 4'b0001;
        step(3);
        check_eq("t3_overrun", 32'(overrun), 32'h1);
        req_in = 4'b0000;
        step(3);
        do_clear(4'b0001);
        check_eq("t3_pending_clr", 32'(pending), 32'h0);
        check_eq("t3_overrun_clr", 32'(overrun), 32'h0);
        step(2);

        // Clear of source 1 on the same cycle its event fires: set wins
        req_in = 4'b0010;
        step(2);
        do_clear(4'b0010);
        check_eq("t4_pending_kept", 32'(pending), 32'h2);
        check_eq("t4_overrun", 32'(overrun), 32'h0);
        check_eq("t4_ack", 32'(clr_ack), 32'h1);
        req_in = 4'b0000;
        step(3);
        do_clear(4'b0010);
        check_eq("t4_pending_clr", 32'(pending), 32'h0);
        step(2);

        // Level mode on source 3
        edge_mode = 4'b0000;
        req_in    = 4'b1000;
        step(3);
        check_eq("t5_pending", 32'(pending), 32'h8);
        step();
        check_eq("t5_overrun", 32'(overrun), 32'h8);
        do_clear(4'b1000);
        check_eq("t5_pending_relatch", 32'(pending), 32'h8);
        check_eq("t5_ack", 32'(clr_ack), 32'h1);
        req_in = 4'b0000;
        step(3);
        clr_valid = 1'b1;
        clr_mask  = 4'b0000;
        step();
        check_eq("t5_ack_mask0", 32'(clr_ack), 32'h1);
        check_eq("t5_mask0_keeps", 32'(pending), 32'h8);
        clr_mask = 4'b1111;
        step();
        clr_valid = 1'b0;
        clr_mask  = '0;
        check_eq("t5_ack_b2b", 32'(clr_ack), 32'h1);
        check_eq("t5_pending_clr", 32'(pending), 32'h0);
        check_eq("t5_overrun_clr", 32'(overrun), 32'h0);
        step();
        check_eq("t5_ack_end", 32'(clr_ack), 32'h0);

        // All lines held high across a mid-operation reset
        edge_mode = 4'b1111;
        req_in    = 4'b1111;
        step(4);
        check_eq("t6_pending_pre", 32'(pending), 32'hf);
        check_eq("t6_irq_pre", 32'(irq_out), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_pending", 32'(pending), 32'h0);
        check_eq("t6_rst_irq", 32'(irq_out), 32'h0);
        check_eq("t6_rst_src", 32'(src_id), 32'h0);
        check_eq("t6_rst_overrun", 32'(overrun), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check_eq("t6_post_early", 32'(pending), 32'h0);
        step();
        check_eq("t6_post_pending", 32'(pending), 32'hf);
        check_eq("t6_post_overrun", 32'(overrun), 32'h0);
        step();
        check_eq("t6_post_irq", 32'(irq_out), 32'h1);
        check_eq("t6_post_src", 32'(src_id), 32'h0);
        check_eq("t6_post_overrun2", 32'(overrun), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
